// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, opcodes,
// condition codes and the latched instruction-register layout.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_LDR  = 4'hD;
  localparam logic [3:0] OP_STR  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Only the instruction fields the sequencer acts on are kept in the IR.
  typedef struct packed {
    logic [3:0]  cond;
    logic [3:0]  op;
    logic        s;
    logic [15:0] imm;
  } ir_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return !(op inside {OP_B, OP_LDR, OP_STR, OP_HALT});
  endfunction

endpackage

// File: rtl/instr_sequencer_cond_eval.sv
// Condition-code evaluator: decides whether an instruction executes given
// its 4-bit condition field and the current NZCV flags.
module cond_eval
  import instr_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    // NOTE: every path assigns pass (default first), so no latch is inferred.
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT control
// FSM holding PC and IR, with all strobes decoded from state, IR and inputs.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = 16,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [31:0]         instr,
  input  logic [3:0]          flags,
  input  logic                mem_ready,
  output logic [PC_WIDTH-1:0] fetch_address,
  output logic                ir_load,
  output logic                reg_we,
  output logic                flags_we,
  output logic                ram_rw,
  output logic                sel_ldr,
  output logic                sel_add,
  output logic [2:0]          state,
  output logic                halted
);

  state_t              cur_state;
  logic [PC_WIDTH-1:0] pc;
  ir_t                 ir;
  logic                pass;
  logic                unused_instr_bits;

  assign unused_instr_bits = ^{instr[22:19], instr[2:0]};

  cond_eval u_cond_eval (
    .cond  (ir.cond),
    .flags (flags),
    .pass  (pass)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      cur_state <= S_FETCH;
      pc        <= PC_WIDTH'(RESET_PC);
      ir        <= '0;
    end else begin
      case (cur_state)
        S_FETCH: begin
          if (en) begin
            ir        <= {instr[31:23], instr[18:3]};
            cur_state <= S_DECODE;
          end
        end
        S_DECODE: cur_state <= S_EXEC;
        S_EXEC: begin
          if (ir.op == OP_HALT) begin
            cur_state <= S_HALT;
          end else if (!pass) begin
            cur_state <= S_FETCH;
            pc        <= pc + 1'b1;
          end else if (ir.op == OP_LDR || ir.op == OP_STR) begin
            cur_state <= S_MEM;
          end else if (ir.op == OP_B) begin
            cur_state <= S_FETCH;
            pc        <= PC_WIDTH'(ir.imm);
          end else begin
            cur_state <= S_WB;
          end
        end
        S_MEM: begin
          // A store retires straight from MEM; a load still needs WB.
          if (mem_ready) begin
            if (ir.op == OP_LDR) begin
              cur_state <= S_WB;
            end else begin
              cur_state <= S_FETCH;
              pc        <= pc + 1'b1;
            end
          end
        end
        S_WB: begin
          cur_state <= S_FETCH;
          pc        <= pc + 1'b1;
        end
        S_HALT:  cur_state <= S_HALT;
        default: cur_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ir_load  = 1'b0;
    reg_we   = 1'b0;
    flags_we = 1'b0;
    ram_rw   = 1'b0;
    sel_ldr  = 1'b0;
    sel_add  = 1'b0;
    halted   = 1'b0;
    case (cur_state)
      S_FETCH: ir_load = en;
      S_EXEC:  flags_we = pass && ir.s && is_alu_op(ir.op);
      S_MEM: begin
        sel_add = 1'b1;
        ram_rw  = (ir.op == OP_STR);
      end
      S_WB: begin
        reg_we  = 1'b1;
        sel_ldr = (ir.op == OP_LDR);
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign fetch_address = pc;
  assign state         = cur_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: each cycle's expected outputs are
// queued as stimulus is driven, then popped and compared against the DUT.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] pc;
    logic [6:0]  strb; // {ir_load, reg_we, flags_we, ram_rw, sel_ldr, sel_add, halted}
  } exp_t;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] IL   = 7'b1000000;
  localparam logic [6:0] RW   = 7'b0100000;
  localparam logic [6:0] FW   = 7'b0010000;
  localparam logic [6:0] RR   = 7'b0001000;
  localparam logic [6:0] SL   = 7'b0000100;
  localparam logic [6:0] SA   = 7'b0000010;
  localparam logic [6:0] HT   = 7'b0000001;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] instr;
  logic [3:0]  flags;
  logic        mem_ready;
  logic [15:0] fetch_address;
  logic        ir_load, reg_we, flags_we, ram_rw, sel_ldr, sel_add;
  logic [2:0]  state;
  logic        halted;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  instr_sequencer #(.PC_WIDTH(16), .RESET_PC(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .instr         (instr),
    .flags         (flags),
    .mem_ready     (mem_ready),
    .fetch_address (fetch_address),
    .ir_load       (ir_load),
    .reg_we        (reg_we),
    .flags_we      (flags_we),
    .ram_rw        (ram_rw),
    .sel_ldr       (sel_ldr),
    .sel_add       (sel_add),
    .state         (state),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] o,
                                     input logic s, input logic [15:0] imm);
    return {c, o, s, 4'b0000, imm, 3'b000};
  endfunction

  function automatic exp_t ex(input state_t s, input logic [15:0] p, input logic [6:0] strb);
    exp_t x;
    x.st   = s;
    x.pc   = p;
    x.strb = strb;
    return x;
  endfunction

  // Drive one cycle's inputs, queue its expectation, compare, advance a cycle.
  task automatic cyc(input string tag, input logic e, input logic r, input logic m,
                     input logic [3:0] f, input exp_t x);
    exp_t got, want;
    en        = e;
    rst_n     = r;
    mem_ready = m;
    flags     = f;
    sb.push_back(x);
    #1;
    got  = '{st: state, pc: fetch_address,
             strb: {ir_load, reg_we, flags_we, ram_rw, sel_ldr, sel_add, halted}};
    want = sb.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed st=%0d pc=%h strb=%b expected st=%0d pc=%h strb=%b",
             tag, got.st, got.pc, got.strb, want.st, want.pc, want.strb);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mem_ready = 1'b0; flags = 4'h0; instr = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    cyc("reset_state", 0, 1, 0, 4'h0, ex(S_FETCH, 16'h0000, NONE));
    cyc("en_low_hold", 0, 1, 0, 4'h0, ex(S_FETCH, 16'h0000, NONE));

    // ADD AL, s=1
    instr = mk(COND_AL, 4'h0, 1'b1, 16'h1234);
    cyc("add_fetch",  1, 1, 0, 4'h0, ex(S_FETCH,  16'h0000, IL));
    cyc("add_decode", 0, 1, 0, 4'h0, ex(S_DECODE, 16'h0000, NONE));
    cyc("add_exec",   0, 1, 0, 4'h0, ex(S_EXEC,   16'h0000, FW));
    cyc("add_wb",     0, 1, 0, 4'h0, ex(S_WB,     16'h0000, RW));
    cyc("add_done",   0, 1, 0, 4'h0, ex(S_FETCH,  16'h0001, NONE));

    // LDR AL with three stalled MEM cycles
    instr = mk(COND_AL, OP_LDR, 1'b1, 16'h0000);
    cyc("ldr_fetch",  1, 1, 0, 4'h0, ex(S_FETCH,  16'h0001, IL));
    cyc("ldr_decode", 0, 1, 0, 4'h0, ex(S_DECODE, 16'h0001, NONE));
    cyc("ldr_exec",   0, 1, 0, 4'h0, ex(S_EXEC,   16'h0001, NONE));
    for (int i = 0; i < 3; i++)
      cyc("ldr_stall", 0, 1, 0, 4'h0, ex(S_MEM, 16'h0001, SA));
    cyc("ldr_mem_rdy", 0, 1, 1, 4'h0, ex(S_MEM,   16'h0001, SA));
    cyc("ldr_wb",      0, 1, 0, 4'h0, ex(S_WB,    16'h0001, RW | SL));
    cyc("ldr_done",    0, 1, 0, 4'h0, ex(S_FETCH, 16'h0002, NONE));

    // STR EQ, Z=0 -> skipped
    instr = mk(COND_EQ, OP_STR, 1'b0, 16'h0000);
    cyc("streq0_fetch",  1, 1, 0, 4'h0, ex(S_FETCH,  16'h0002, IL));
    cyc("streq0_decode", 0, 1, 0, 4'h0, ex(S_DECODE, 16'h0002, NONE));
    cyc("streq0_exec",   0, 1, 0, 4'h0, ex(S_EXEC,   16'h0002, NONE));
    cyc("streq0_done",   0, 1, 0, 4'h0, ex(S_FETCH,  16'h0003, NONE));

    // STR EQ, Z=1 -> single-cycle MEM write
    cyc("streq1_fetch",  1, 1, 0, 4'h4, ex(S_FETCH,  16'h0003, IL));
    cyc("streq1_decode", 0, 1, 0, 4'h4, ex(S_DECODE, 16'h0003, NONE));
    cyc("streq1_exec",   0, 1, 0, 4'h4, ex(S_EXEC,   16'h0003, NONE));
    cyc("streq1_mem",    0, 1, 1, 4'h4, ex(S_MEM,    16'h0003, SA | RR));
    cyc("streq1_done",   0, 1, 0, 4'h0, ex(S_FETCH,  16'h0004, NONE));

    // ADD LT s=1 with N=1, V=0 -> passes
    instr = mk(COND_LT, 4'h1, 1'b1, 16'h0000);
    cyc("addlt_fetch",  1, 1, 0, 4'h8, ex(S_FETCH,  16'h0004, IL));
    cyc("addlt_decode", 0, 1, 0, 4'h8, ex(S_DECODE, 16'h0004, NONE));
    cyc("addlt_exec",   0, 1, 0, 4'h8, ex(S_EXEC,   16'h0004, FW));
    cyc("addlt_wb",     0, 1, 0, 4'h0, ex(S_WB,     16'h0004, RW));
    cyc("addlt_done",   0, 1, 0, 4'h0, ex(S_FETCH,  16'h0005, NONE));

    // ADD GT s=1 with Z=1 -> fails
    instr = mk(COND_GT, 4'h2, 1'b1, 16'h0000);
    cyc("addgt_fetch",  1, 1, 0, 4'h4, ex(S_FETCH,  16'h0005, IL));
    cyc("addgt_decode", 0, 1, 0, 4'h4, ex(S_DECODE, 16'h0005, NONE));
    cyc("addgt_exec",   0, 1, 0, 4'h4, ex(S_EXEC,   16'h0005, NONE));
    cyc("addgt_done",   0, 1, 0, 4'h0, ex(S_FETCH,  16'h0006, NONE));

    // Reset during an LDR MEM stall
    instr = mk(COND_AL, OP_LDR, 1'b0, 16'h0000);
    cyc("ldrrst_fetch",  1, 1, 0, 4'h0, ex(S_FETCH,  16'h0006, IL));
    cyc("ldrrst_decode", 0, 1, 0, 4'h0, ex(S_DECODE, 16'h0006, NONE));
    cyc("ldrrst_exec",   0, 1, 0, 4'h0, ex(S_EXEC,   16'h0006, NONE));
    cyc("ldrrst_stall",  0, 1, 0, 4'h0, ex(S_MEM,    16'h0006, SA));
    cyc("ldrrst_assert", 0, 0, 0, 4'h0, ex(S_MEM,    16'h0006, SA));
    cyc("ldrrst_after",  0, 1, 0, 4'h0, ex(S_FETCH,  16'h0000, NONE));

    // Branches across the top of the address space
    instr = mk(COND_AL, OP_B, 1'b0, 16'hFFFF);
    cyc("b_ffff_fetch", 1, 1, 0, 4'h0, ex(S_FETCH,  16'h0000, IL));
    cyc("b_ffff_dec",   0, 1, 0, 4'h0, ex(S_DECODE, 16'h0000, NONE));
    cyc("b_ffff_exec",  0, 1, 0, 4'h0, ex(S_EXEC,   16'h0000, NONE));
    instr = mk(COND_AL, OP_B, 1'b0, 16'h0040);
    cyc("b_40_fetch",   1, 1, 0, 4'h0, ex(S_FETCH,  16'hFFFF, IL));
    cyc("b_40_dec",     0, 1, 0, 4'h0, ex(S_DECODE, 16'hFFFF, NONE));
    cyc("b_40_exec",    0, 1, 0, 4'h0, ex(S_EXEC,   16'hFFFF, NONE));
    instr = mk(COND_AL, OP_B, 1'b0, 16'hFFFF);
    cyc("b_back_fetch", 1, 1, 0, 4'h0, ex(S_FETCH,  16'h0040, IL));
    cyc("b_back_dec",   0, 1, 0, 4'h0, ex(S_DECODE, 16'h0040, NONE));
    cyc("b_back_exec",  0, 1, 0, 4'h0, ex(S_EXEC,   16'h0040, NONE));

    // Non-branch at 0xFFFF wraps PC to 0
    instr = mk(COND_AL, 4'h3, 1'b0, 16'h0000);
    cyc("wrap_fetch",  1, 1, 0, 4'h0, ex(S_FETCH,  16'hFFFF, IL));
    cyc("wrap_decode", 0, 1, 0, 4'h0, ex(S_DECODE, 16'hFFFF, NONE));
    cyc("wrap_exec",   0, 1, 0, 4'h0, ex(S_EXEC,   16'hFFFF, NONE));
    cyc("wrap_wb",     0, 1, 0, 4'h0, ex(S_WB,     16'hFFFF, RW));
    cyc("wrap_done",   0, 1, 0, 4'h0, ex(S_FETCH,  16'h0000, NONE));

    // HALT with NV condition still halts; en toggling has no effect
    instr = mk(COND_NV, OP_HALT, 1'b1, 16'h0000);
    cyc("halt_fetch",  1, 1, 0, 4'h0, ex(S_FETCH,  16'h0000, IL));
    cyc("halt_decode", 0, 1, 0, 4'h0, ex(S_DECODE, 16'h0000, NONE));
    cyc("halt_exec",   0, 1, 0, 4'h0, ex(S_EXEC,   16'h0000, NONE));
    for (int i = 0; i < 20; i++)
      cyc("halt_hold", i[0], 1, i[1], 4'hF, ex(S_HALT, 16'h0000, HT));
    cyc("halt_rst_assert", 1, 0, 0, 4'h0, ex(S_HALT,  16'h0000, HT));
    cyc("halt_rst_after",  0, 1, 0, 4'h0, ex(S_FETCH, 16'h0000, NONE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 16, width of fetch_address/PC.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-005 SHALL have port en  input  1  run enable; sampled only in FETCH.
REQ-006 SHALL have port instr  input  32  fetched word (cond[31:28], op[27:24], s[23], imm[18:3]).
REQ-007 SHALL have port flags  input  4  current NZCV from flags register.
REQ-008 SHALL have port mem_ready  input  1  RAM access complete this cycle.
REQ-009 SHALL have port fetch_address  output  PC_WIDTH  current PC.
REQ-010 SHALL have ports ir_load, reg_we, flags_we, ram_rw (1=write), sel_ldr (1=RAM data), sel_add (1=data address)  output  1 each.
REQ-011 SHALL have ports state  output  3  current state code; halted  output  1  high in HALT.

Function
REQ-012 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-013 FETCH: ir_load=1 for one cycle only when en=1; en=0 holds in FETCH, all strobes 0.
REQ-014 FETCH->DECODE->EXEC unconditionally, one cycle each; IR latched at end of FETCH.
REQ-015 EXEC SHALL evaluate cond against flags sampled that cycle (EQ 0,NE 1,CS 2,CC 3,MI 4,PL 5,VS 6,VC 7,HI 8,LS 9,GE A,LT B,GT C,LE D,AL E,NV F).
REQ-016 ALU-class op, cond pass: EXEC->WB; flags_we=1 in EXEC iff s=1; reg_we=1, sel_ldr=0 in WB. Total 4 cycles.
REQ-017 OP_LDR, cond pass: EXEC->MEM (sel_add=1, ram_rw=0) held until mem_ready=1, then WB with reg_we=1, sel_ldr=1.
REQ-018 OP_STR, cond pass: EXEC->MEM (sel_add=1, ram_rw=1) held until mem_ready=1, then FETCH; no WB.
REQ-019 mem_ready=1 in first MEM cycle SHALL give single-cycle MEM (LDR 5, STR 4 cycles total).
REQ-020 OP_B, cond pass: EXEC->FETCH with PC <= imm[PC_WIDTH-1:0]; 3 cycles.
REQ-021 OP_HALT: EXEC->HALT; HALT holds all strobes 0 until reset; cond ignored.
REQ-022 Cond fail (any op except HALT): EXEC->FETCH, no reg_we/flags_we/MEM access, PC <= PC+1.
REQ-023 PC SHALL increment by 1 on every non-branch return to FETCH, modulo 2^PC_WIDTH (max wraps to 0).
REQ-024 ram_rw SHALL be 1 only in MEM for STR; reg_we and flags_we never simultaneously with ram_rw.
REQ-025 fetch_address SHALL equal PC in all states; sel_add=0 outside MEM.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force state=FETCH, PC=RESET_PC, IR=0, all strobes 0, halted=0 next cycle, from any state incl. mid-MEM and HALT.
REQ-027 Strobe outputs SHALL be decoded from state/IR so none is asserted in the cycle after reset.

Structure
REQ-028 Shared package SHALL hold state encoding, opcode constants (OP_LDR=4'hD, OP_STR=4'hE, OP_B=4'hC, OP_HALT=4'hF) and cond codes.
REQ-029 Condition evaluation SHALL be sub-module cond_eval (cond, flags -> pass), purely combinational.
REQ-030 PC, IR and state SHALL be the only registers; outputs combinational from them.

Verification
REQ-031 ADD AL s=1, en=1 -> ir_load c0, flags_we c2, reg_we c3, PC 0->1 at c4.
REQ-032 LDR AL, mem_ready low 3 MEM cycles -> sel_add=1 4 cycles, then reg_we=1 with sel_ldr=1, PC=1.
REQ-033 STR EQ with Z=0 -> no MEM, ram_rw never 1, PC+1 after 3 cycles; with Z=1 -> ram_rw=1 in MEM.
REQ-034 B AL imm=0x0040 from PC=0xFFFF -> PC=0x0040; non-branch at PC=0xFFFF -> PC=0x0000.
REQ-035 rst_n=0 during LDR MEM stall -> next cycle state=FETCH, PC=RESET_PC, sel_add=0, reg_we=0.
REQ-036 HALT -> halted=1 and strobes 0 for 20 cycles regardless of en; rst_n=0 -> FETCH, halted=0.
